// File: rtl/video_filter_stage.sv
// video_filter_stage: streaming per-pixel colour filter with valid/ready handshake, one-cycle latency
// Optional feature macro: VIDEO_FILTER_BLUR_EN (mode 3 causal horizontal blur, column counter, history)
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   filter_num, freq_flag     filter mode and tint level, latched on an accepted start-of-frame beat
//   in_data/valid/sop/eop     input pixel stream, in_ready back to the source
//   out_data/valid/sop/eop    filtered pixel stream, out_ready from downstream
//   active_filter             mode applied to the current frame
//   frame_cnt                 frames delivered downstream (end-of-frame handshakes), wraps
module video_filter_stage #(
    parameter int COLOR_W = 8,
    parameter int LINE_W  = 640,
    parameter int FREQ_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           filter_num,
    input  logic [FREQ_W-1:0]    freq_flag,
    input  logic [3*COLOR_W-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic                 in_ready,
    output logic [3*COLOR_W-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    input  logic                 out_ready,
    output logic [2:0]           active_filter,
    output logic [15:0]          frame_cnt
);
    localparam int W = 3 * COLOR_W;
    localparam logic [COLOR_W-1:0] MAX = '1;
    logic              accept;
    logic              out_hs;
    logic [2:0]        mode;
    logic [FREQ_W-1:0] tint;
    logic [FREQ_W-1:0] lvl;
    logic [COLOR_W-1:0] r, g, b, y, r_tint;
    logic [COLOR_W+1:0] y_sum;
    logic [COLOR_W:0]   r_sum;
    logic [W-1:0]       blur_data;
    logic [W-1:0]       next_data;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // A start-of-frame beat already uses the newly requested mode and tint
    assign mode = in_sop ? filter_num : active_filter;
    assign lvl  = in_sop ? freq_flag : tint;

    assign {r, g, b} = in_data;
    assign y_sum  = {2'b0, r} + {1'b0, g, 1'b0} + {2'b0, b};
    assign y      = y_sum[COLOR_W+1:2];
    // Tint is scaled into the top FREQ_W bits of the channel range
    assign r_sum  = {1'b0, r} + ({{(COLOR_W+1-FREQ_W){1'b0}}, lvl} << (COLOR_W - FREQ_W));
    assign r_tint = r_sum[COLOR_W] ? MAX : r_sum[COLOR_W-1:0];

    assign next_data = (mode == 3'd1) ? {y, y, y} :
                       (mode == 3'd2) ? ~in_data :
                       (mode == 3'd3) ? blur_data :
                       (mode == 3'd4) ? {r_tint, g, b} : in_data;

`ifdef VIDEO_FILTER_BLUR_EN
    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    logic [CW-1:0] col, col_cur;
    logic [W-1:0]  h1, h2, p1, p2;

    assign col_cur = in_sop ? '0 : col;
    // At column 0 the history is replaced by the current pixel, so line starts pass unchanged
    assign p1 = (col_cur == '0) ? in_data : h1;
    assign p2 = (col_cur == '0) ? in_data : h2;

    for (genvar k = 0; k < 3; k++) begin : g_blur
        logic [COLOR_W+1:0] s;
        assign s = {2'b0, p2[k*COLOR_W +: COLOR_W]} + {1'b0, p1[k*COLOR_W +: COLOR_W], 1'b0}
                 + {2'b0, in_data[k*COLOR_W +: COLOR_W]};
        assign blur_data[k*COLOR_W +: COLOR_W] = s[COLOR_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col <= '0;
            h1  <= '0;
            h2  <= '0;
        end else if (accept) begin
            col <= (col_cur == CW'(LINE_W - 1)) ? '0 : col_cur + CW'(1);
            h1  <= in_data;
            h2  <= p1;
        end
    end
`else
    logic [31:0] unused_line_w;
    assign unused_line_w = LINE_W;
    assign blur_data = in_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            active_filter <= 3'd0;
            tint          <= '0;
            frame_cnt     <= 16'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= next_data;
                out_sop   <= in_sop;
                out_eop   <= in_eop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && in_sop) begin
                active_filter <= filter_num;
                tint          <= freq_flag;
            end
            if (out_hs && out_eop)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
